// File: rtl/bus_if_px.sv
// bus_if_px: CPU access router between a local scratchpad (SPM) and an external bus,
// with posted writes, stall hold-off of read data and a bounded bus-ready timeout.
module bus_if_px #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int IDX_HI    = 29,
    parameter int IDX_LO    = 27,
    parameter int SPM_IDX   = 1,
    parameter int TMO_W     = 8,
    parameter int TMO_MAX   = 255,
    parameter int POSTED_WR = 1
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              stall,
    input  logic              flush,
    output logic              busy,
    output logic              err,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_,
    input  logic              rw,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    input  logic              bus_grnt_,
    output logic              bus_req_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data
);
    localparam int IDX_W = IDX_HI - IDX_LO + 1;

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

    state_t            state, state_nx;
    logic              p, cur_rw;
    logic [TMO_W-1:0]  cnt;
    logic [DATA_W-1:0] rd_buf;
    logic              valid, spm, posted, issue, done, tmo, fin;

    assign valid  = !as_ && !flush;
    assign spm    = addr[IDX_HI:IDX_LO] == IDX_W'(SPM_IDX);
    assign posted = (POSTED_WR != 0) && rw;
    assign issue  = state == IDLE && valid && !spm;
    assign done   = state == ACCESS && !bus_rdy_;
    assign tmo    = state == ACCESS && bus_rdy_ && cnt == TMO_W'(TMO_MAX);
    assign fin    = done || tmo;

    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (issue) state_nx = REQ;
            REQ:     if (!bus_grnt_) state_nx = ACCESS;
            ACCESS:  if (fin) state_nx = (!p && stall) ? STALL : IDLE;
            default: if (!stall) state_nx = IDLE;
        endcase
    end

    // A posted write frees the pipeline; it only holds again if a new access arrives.
    always_comb begin
        spm_as_ = !(state == IDLE && valid && spm && !stall);
        rd_data = (!spm_as_ && !rw)              ? spm_rd_data :
                  (done && !cur_rw)              ? bus_rd_data :
                  (state == STALL && !cur_rw)    ? rd_buf      : '0;
        busy    = (state == IDLE)                    ? issue && !posted :
                  (state == REQ || state == ACCESS)  ? !fin && (!p || valid) : 1'b0;
        err     = tmo;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            p           <= 1'b0;
            cur_rw      <= 1'b0;
            cnt         <= '0;
            rd_buf      <= '0;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
        end else begin
            if (issue) begin
                bus_req_    <= 1'b0;
                bus_addr    <= addr;
                bus_rw      <= rw;
                bus_wr_data <= wr_data;
                cur_rw      <= rw;
                p           <= posted;
            end
            if (state == REQ && !bus_grnt_) begin
                bus_as_ <= 1'b0;
                cnt     <= '0;
            end
            if (state == ACCESS) bus_as_ <= 1'b1;
            if (state == ACCESS && bus_rdy_ && !tmo) cnt <= cnt + 1'b1;
            if (fin) begin
                bus_req_    <= 1'b1;
                bus_addr    <= '0;
                bus_rw      <= 1'b0;
                bus_wr_data <= '0;
                p           <= 1'b0;
                if (!cur_rw) rd_buf <= done ? bus_rd_data : '0;
            end
        end
    end
endmodule
